// File: rtl/autoconfig_master.sv
// Autoconfig enumeration master: scans the config window at 0xE80000 and places each board in the 0x200000-0x9FFFFF pool.
// Optional feature macro AUTOCONFIG_MASTER_SIZE_8M_EN: allocate size-code-000 (8M) boards instead of shutting them up.
module autoconfig_master (
   input  logic        MB_CLK,
   input  logic        RESET,
   input  logic        START,
   output logic        BUSY,
   output logic        DONE,
   output logic [3:0]  BOARD_COUNT,
   output logic        AS_N,
   output logic        UDS_N,
   output logic        RW,
   output logic [22:0] ADDRESS,
   output logic [3:0]  DATA_OUT,
   output logic        DATA_OE,
   input  logic [3:0]  DATA_IN,
   input  logic        DTACK_N
);

   typedef enum logic [2:0] {
      IDLE,
      RD_TYPE_HI,
      RD_TYPE_LO,
      ALLOC,
      WR_BASE_LO,
      WR_BASE_HI,
      WR_SHUTUP,
      FINISH
   } top_e;

   typedef enum logic [1:0] {
      PH_ADDR,
      PH_STROBE,
      PH_WAIT,
      PH_END
   } phase_e;

   localparam logic [7:0]  POOL_START = 8'h20;
   localparam logic [8:0]  POOL_END   = 9'h0A0;
   localparam logic [16:0] CFG_PAGE   = 17'h1D000;
   localparam logic [5:0]  WAIT_LIMIT = 6'd63;

   top_e       state_q, state_d;
   phase_e     phase_q, phase_d;
   logic [5:0] waitCnt_q, waitCnt_d;
   logic [3:0] nibble_q, nibble_d;
   logic [2:0] sizeCode_q, sizeCode_d;
   logic [7:0] base_q, base_d;
   logic [7:0] ptr_q, ptr_d;
   logic [3:0] count_q, count_d;
   logic       done_q, done_d;

   logic [8:0] sizeUnits;
   logic [8:0] roundedBase;
   logic [8:0] allocEnd;
   logic       fits;

   logic       busState;
   logic       isWrite;
   logic [5:0] wordOffset;
   logic [3:0] wrNibble;

   // Board size in 64K pool units, and the aligned placement it would get at the current pointer.
   always_comb begin
      unique case (sizeCode_q)
         3'b001:  sizeUnits = 9'd1;
         3'b010:  sizeUnits = 9'd2;
         3'b011:  sizeUnits = 9'd4;
         3'b100:  sizeUnits = 9'd8;
         3'b101:  sizeUnits = 9'd16;
         3'b110:  sizeUnits = 9'd32;
         3'b111:  sizeUnits = 9'd64;
         default: sizeUnits = 9'd128;
      endcase
      roundedBase = ({1'b0, ptr_q} + sizeUnits - 9'd1) & ~(sizeUnits - 9'd1);
      allocEnd    = roundedBase + sizeUnits;
      fits        = (allocEnd <= POOL_END);
`ifdef AUTOCONFIG_MASTER_SIZE_8M_EN
      // An 8M board cannot be aligned inside the pool; it only fits as the very first allocation.
      if (sizeCode_q == 3'b000) begin
         roundedBase = {1'b0, ptr_q};
         allocEnd    = roundedBase + sizeUnits;
         fits        = (ptr_q == POOL_START);
      end
`else
      if (sizeCode_q == 3'b000) begin
         fits = 1'b0;
      end
`endif
   end

   always_ff @(posedge MB_CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         phase_q    <= PH_ADDR;
         waitCnt_q  <= '0;
         nibble_q   <= '0;
         sizeCode_q <= '0;
         base_q     <= '0;
         ptr_q      <= POOL_START;
         count_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         waitCnt_q  <= waitCnt_d;
         nibble_q   <= nibble_d;
         sizeCode_q <= sizeCode_d;
         base_q     <= base_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      waitCnt_d  = waitCnt_q;
      nibble_d   = nibble_q;
      sizeCode_d = sizeCode_q;
      base_d     = base_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      done_d     = done_q;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               state_d = RD_TYPE_HI;
               phase_d = PH_ADDR;
               ptr_d   = POOL_START;
               count_d = '0;
               done_d  = 1'b0;
            end
         end
         ALLOC: begin
            phase_d = PH_ADDR;
            if (fits) begin
               base_d  = roundedBase[7:0];
               state_d = WR_BASE_LO;
            end else begin
               state_d = WR_SHUTUP;
            end
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: begin
            unique case (phase_q)
               PH_ADDR: phase_d = PH_STROBE;
               PH_STROBE: begin
                  phase_d   = PH_WAIT;
                  waitCnt_d = '0;
               end
               PH_WAIT: begin
                  if (!DTACK_N) begin
                     nibble_d = DATA_IN;
                     phase_d  = PH_END;
                  end else if (waitCnt_q == WAIT_LIMIT) begin
                     // Nobody answered: an empty slot terminates the whole scan.
                     state_d = FINISH;
                     phase_d = PH_ADDR;
                  end else begin
                     waitCnt_d = waitCnt_q + 6'd1;
                  end
               end
               default: begin
                  phase_d = PH_ADDR;
                  unique case (state_q)
                     RD_TYPE_HI: state_d = (nibble_q[3:2] == 2'b11) ? RD_TYPE_LO : FINISH;
                     RD_TYPE_LO: begin
                        sizeCode_d = nibble_q[2:0];
                        state_d    = ALLOC;
                     end
                     WR_BASE_LO: state_d = WR_BASE_HI;
                     WR_BASE_HI: begin
                        ptr_d   = base_q + sizeUnits[7:0];
                        count_d = count_q + 4'd1;
                        state_d = (count_q == 4'd14) ? FINISH : RD_TYPE_HI;
                     end
                     default: state_d = RD_TYPE_HI;
                  endcase
               end
            endcase
         end
      endcase
   end

   always_comb begin
      busState   = 1'b0;
      isWrite    = 1'b0;
      wordOffset = 6'h00;
      wrNibble   = 4'h0;
      unique case (state_q)
         RD_TYPE_HI: begin
            busState   = 1'b1;
            wordOffset = 6'h00;
         end
         RD_TYPE_LO: begin
            busState   = 1'b1;
            wordOffset = 6'h01;
         end
         WR_BASE_LO: begin
            busState   = 1'b1;
            isWrite    = 1'b1;
            wordOffset = 6'h25;
            wrNibble   = base_q[3:0];
         end
         WR_BASE_HI: begin
            busState   = 1'b1;
            isWrite    = 1'b1;
            wordOffset = 6'h24;
            wrNibble   = base_q[7:4];
         end
         WR_SHUTUP: begin
            busState   = 1'b1;
            isWrite    = 1'b1;
            wordOffset = 6'h26;
         end
         default: ;
      endcase
      AS_N        = !(busState && ((phase_q == PH_STROBE) || (phase_q == PH_WAIT)));
      UDS_N       = AS_N;
      RW          = !(busState && isWrite);
      ADDRESS     = busState ? {CFG_PAGE, wordOffset} : 23'h0;
      DATA_OUT    = (busState && isWrite) ? wrNibble : 4'h0;
      DATA_OE     = busState && isWrite;
      BUSY        = (state_q != IDLE);
      DONE        = done_q;
      BOARD_COUNT = count_q;
   end

endmodule

// File: tb/tb_autoconfig_master.sv
// Bench for autoconfig_master: emulates a chain of autoconfig boards and checks every bus cycle against a placement model.
module tb_autoconfig_master;

   logic        MB_CLK;
   logic        RESET;
   logic        START;
   logic        BUSY;
   logic        DONE;
   logic [3:0]  BOARD_COUNT;
   logic        AS_N;
   logic        UDS_N;
   logic        RW;
   logic [22:0] ADDRESS;
   logic [3:0]  DATA_OUT;
   logic        DATA_OE;
   logic [3:0]  DATA_IN;
   logic        DTACK_N;

   autoconfig_master dut (
      .MB_CLK(MB_CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
      .BOARD_COUNT(BOARD_COUNT), .AS_N(AS_N), .UDS_N(UDS_N), .RW(RW),
      .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
      .DATA_IN(DATA_IN), .DTACK_N(DTACK_N)
   );

`ifdef AUTOCONFIG_MASTER_SIZE_8M_EN
   localparam bit MODEL_8M = 1'b1;
`else
   localparam bit MODEL_8M = 1'b0;
`endif

   typedef struct {
      bit          rw;
      logic [23:0] addr;
      logic [3:0]  data;
   } txn_t;

   txn_t        expQ[$];
   int          expCount;
   logic [3:0]  typeHi[0:31];
   logic [3:0]  sizeNib[0:31];
   int          nBoards;
   int          boardIdx;
   int          errors;
   int          checks;

   bit          inCycle;
   bit          responding;
   bit          curRw;
   logic [23:0] curAddr;
   int          lowCnt;
   int          ackDelay;

   initial MB_CLK = 1'b0;
   always #5 MB_CLK = ~MB_CLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pushTxn(input bit rw, input int off, input int data);
      txn_t t;
      t.rw   = rw;
      t.addr = 24'hE80000 + off[23:0];
      t.data = data[3:0];
      expQ.push_back(t);
   endtask

   // Expected bus traffic derived straight from the board list and the pool placement rules.
   task automatic buildModel();
      int ptr, units, base, idx, code;
      bit fit, fin;
      expQ.delete();
      ptr = 'h20;
      expCount = 0;
      idx = 0;
      fin = 1'b0;
      while (!fin) begin
         pushTxn(1'b1, 'h00, 0);
         if (idx >= nBoards) begin
            fin = 1'b1;
         end else if (typeHi[idx][3:2] != 2'b11) begin
            fin = 1'b1;
         end else begin
            pushTxn(1'b1, 'h02, 0);
            code  = int'(sizeNib[idx]) % 8;
            units = (code == 0) ? 128 : (1 << (code - 1));
            if (code == 0) begin
               base = ptr;
               fit  = MODEL_8M && (ptr == 'h20);
            end else begin
               base = ((ptr + units - 1) / units) * units;
               fit  = (base + units) <= 'hA0;
            end
            if (fit) begin
               pushTxn(1'b0, 'h4A, base % 16);
               pushTxn(1'b0, 'h48, base / 16);
               ptr = base + units;
               expCount++;
               if (expCount == 15) fin = 1'b1;
            end else begin
               pushTxn(1'b0, 'h4C, 0);
            end
            idx++;
         end
      end
   endtask

   function automatic int lastHiNibble();
      int v;
      v = -1;
      foreach (expQ[i]) if (expQ[i].addr == 24'hE80048) v = int'(expQ[i].data);
      return v;
   endfunction

   // Board chain emulator and per-cycle comparison of every bus transaction.
   always @(negedge MB_CLK) begin
      if (!RESET) begin
         DTACK_N = 1'b1;
         inCycle = 1'b0;
         lowCnt  = 0;
      end else if (!AS_N) begin
         if (!inCycle) begin
            inCycle    = 1'b1;
            lowCnt     = 0;
            ackDelay   = $urandom_range(0, 3);
            curAddr    = {ADDRESS, 1'b0};
            curRw      = RW;
            responding = (boardIdx < nBoards);
            checkOutput("busy during cycle", BUSY, 1);
            checkOutput("data_oe matches write", DATA_OE, !RW);
            checkOutput("bus cycle expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
               txn_t e;
               e = expQ.pop_front();
               checkOutput("cycle address", curAddr, e.addr);
               checkOutput("cycle rw", curRw, e.rw);
               if (!e.rw) checkOutput("write nibble", DATA_OUT, e.data);
            end
         end
         checkOutput("uds with as", UDS_N, 0);
         lowCnt++;
         if (responding && lowCnt > ackDelay) begin
            DTACK_N = 1'b0;
            DATA_IN = (curAddr == 24'hE80000) ? typeHi[boardIdx] : sizeNib[boardIdx];
         end
      end else if (inCycle) begin
         inCycle = 1'b0;
         DTACK_N = 1'b1;
         if (!responding) begin
            checkOutput("timeout strobe clocks", lowCnt, 65);
         end else if (!curRw && (curAddr == 24'hE80048 || curAddr == 24'hE8004C)) begin
            boardIdx++;
         end
      end
   end

   task automatic applyStimulus();
      @(negedge MB_CLK);
      START = 1'b1;
      @(negedge MB_CLK);
      START = 1'b0;
      checkOutput("busy after start", BUSY, 1);
      checkOutput("done cleared by start", DONE, 0);
   endtask

   task automatic runEnum(input int pinCount, input int pinHi, input bit extraStart);
      bit seen;
      buildModel();
      if (pinCount >= 0) checkOutput("model count", expCount, pinCount);
      if (pinHi >= 0) checkOutput("model last 0x48 nibble", lastHiNibble(), pinHi);
      boardIdx = 0;
      applyStimulus();
      if (extraStart) begin
         repeat (3) @(negedge MB_CLK);
         if (BUSY) begin
            START = 1'b1;
            @(negedge MB_CLK);
            START = 1'b0;
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge MB_CLK);
         if (DONE) seen = 1'b1;
      end
      checkOutput("done reached", seen, 1);
      checkOutput("busy after done", BUSY, 0);
      checkOutput("board count", BOARD_COUNT, expCount);
      checkOutput("all cycles seen", expQ.size(), 0);
      if (pinCount >= 0) checkOutput("board count literal", BOARD_COUNT, pinCount);
   endtask

   task automatic resetMidWrite();
      bit found;
      nBoards = 1;
      typeHi[0] = 4'hC;
      sizeNib[0] = 4'h4;
      buildModel();
      boardIdx = 0;
      applyStimulus();
      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge MB_CLK);
         if (!AS_N && ADDRESS == 23'h740024) found = 1'b1;
      end
      checkOutput("reached 0x48 strobe", found, 1);
      #2 RESET = 1'b0;
      #1;
      checkOutput("rst as_n", AS_N, 1);
      checkOutput("rst uds_n", UDS_N, 1);
      checkOutput("rst rw", RW, 1);
      checkOutput("rst address", ADDRESS, 0);
      checkOutput("rst data_out", DATA_OUT, 0);
      checkOutput("rst data_oe", DATA_OE, 0);
      checkOutput("rst busy", BUSY, 0);
      checkOutput("rst done", DONE, 0);
      checkOutput("rst board count", BOARD_COUNT, 0);
      expQ.delete();
      @(negedge MB_CLK);
      #2 RESET = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge MB_CLK);
         checkOutput("quiet after reset", {AS_N, BUSY, DONE, DATA_OE}, 4'b1000);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      RESET = 1'b0;
      START = 1'b0;
      DTACK_N = 1'b1;
      DATA_IN = 4'h0;
      nBoards = 0;
      boardIdx = 0;
      inCycle = 1'b0;
      repeat (2) @(negedge MB_CLK);
      checkOutput("reset as_n", AS_N, 1);
      checkOutput("reset rw", RW, 1);
      checkOutput("reset address", ADDRESS, 0);
      checkOutput("reset busy", BUSY, 0);
      checkOutput("reset done", DONE, 0);
      checkOutput("reset board count", BOARD_COUNT, 0);
      RESET = 1'b1;
      repeat (2) @(negedge MB_CLK);

      $display("[TB] single 512K board");
      nBoards = 1; typeHi[0] = 4'hC; sizeNib[0] = 4'h4;
      runEnum(1, 2, 1'b0);

      $display("[TB] 512K then 1M");
      nBoards = 2; typeHi[0] = 4'hC; sizeNib[0] = 4'h4; typeHi[1] = 4'hC; sizeNib[1] = 4'h5;
      runEnum(2, 3, 1'b0);

      $display("[TB] empty slot");
      nBoards = 0;
      runEnum(0, -1, 1'b0);

      $display("[TB] 4M then 8M");
      nBoards = 2; typeHi[0] = 4'hC; sizeNib[0] = 4'h7; typeHi[1] = 4'hC; sizeNib[1] = 4'h0;
      runEnum(1, 4, 1'b0);

      $display("[TB] sixteen 64K boards");
      nBoards = 16;
      for (int i = 0; i < 16; i++) begin
         typeHi[i] = 4'hC;
         sizeNib[i] = 4'h1;
      end
      runEnum(15, 2, 1'b0);

      $display("[TB] invalid type nibble");
      nBoards = 1; typeHi[0] = 4'h8; sizeNib[0] = 4'h4;
      runEnum(0, -1, 1'b0);

      $display("[TB] reset during 0x48 write");
      resetMidWrite();
      nBoards = 2; typeHi[0] = 4'hC; sizeNib[0] = 4'h4; typeHi[1] = 4'hD; sizeNib[1] = 4'hD;
      runEnum(2, 3, 1'b0);

      $display("[TB] randomized chains");
      for (int r = 0; r < 25; r++) begin
         nBoards = $urandom_range(0, 7);
         for (int i = 0; i < nBoards; i++) begin
            if ($urandom_range(0, 7) == 0) typeHi[i] = 4'($urandom_range(0, 11));
            else typeHi[i] = 4'($urandom_range(12, 15));
            sizeNib[i] = 4'($urandom_range(0, 15));
         end
         runEnum(-1, -1, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
